// File: rtl/clint_ng_pkg.sv
// rtl/clint_ng_pkg.sv - address map, tick mode and hart decode shared by the CLINT
package clint_ng_pkg;

    typedef enum logic {
        TICK_RTC,
        TICK_DIV
    } tick_mode_e;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;
    localparam logic [15:0] SSIP_BASE     = 16'hC000;

    // Addresses below base wrap to a huge index, so one "< NR_HARTS" test bounds both ends.
    function automatic int hart_idx(input logic [15:0] addr, input logic [15:0] base,
                                    input int shift);
        logic [15:0] off;
        off = addr - base;
        return int'({16'b0, off} >> shift);
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// rtl/clint_tick_gen.sv - mtime tick source: synchronised RTC edge or clock prescaler
module clint_tick_gen
    import clint_ng_pkg::*;
#(
    parameter tick_mode_e TICK_MODE   = TICK_RTC,
    parameter int         PRESCALE    = 100,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rtc_i,
    output logic tick_o
);

    generate
        if (TICK_MODE == TICK_RTC) begin : g_rtc
            // Top bit is one stage past the synchroniser and serves as the previous sample.
            logic [SYNC_STAGES:0] sync_q;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-1:0], rtc_i};
                end
            end

            assign tick_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
        end else begin : g_div
            localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
            logic [CW-1:0] cnt_q;

            assign tick_o = (cnt_q == CW'(PRESCALE - 1));

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else if (tick_o) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/clint_timer_ng.sv
// rtl/clint_timer_ng.sv - core-local interruptor: mtime, per-hart mtimecmp/msip/ssip and timer IRQs
module clint_timer_ng
    import clint_ng_pkg::*;
#(
    parameter int         NR_HARTS    = 1,
    parameter tick_mode_e TICK_MODE   = TICK_RTC,
    parameter int         PRESCALE    = 100,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [15:0]         addr_i,
    input  logic [63:0]         wdata_i,
    input  logic [7:0]          be_i,
    output logic                rvalid_o,
    output logic [63:0]         rdata_o,
    output logic                err_o,
    input  logic                rtc_i,
    input  logic                stop_i,
    output logic [NR_HARTS-1:0] timer_irq_o,
    output logic [NR_HARTS-1:0] ipi_o,
    output logic [NR_HARTS-1:0] sip_o
);

    logic [15:0]         addr_a;
    int                  msip_idx;
    int                  cmp_idx;
    int                  ssip_idx;
    logic                sel_msip;
    logic                sel_cmp;
    logic                sel_mtime;
    logic                sel_ssip;
    logic                wr;
    logic                tick;
    logic [63:0]         rd_data;
    logic                rd_err;

    logic [63:0]         mtime_q;
    logic [63:0]         mtimecmp_q [NR_HARTS];
    logic [NR_HARTS-1:0] msip_q;
    logic [NR_HARTS-1:0] ssip_q;
    logic [NR_HARTS-1:0] irq_q;
    logic                rvalid_q;
    logic                err_q;
    logic [63:0]         rdata_q;

    clint_tick_gen #(
        .TICK_MODE  (TICK_MODE),
        .PRESCALE   (PRESCALE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_gen (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .rtc_i (rtc_i),
        .tick_o(tick)
    );

    always_comb begin
        addr_a    = addr_i & 16'hFFF8;
        msip_idx  = hart_idx(addr_a, MSIP_BASE, 2);
        cmp_idx   = hart_idx(addr_a, MTIMECMP_BASE, 3);
        ssip_idx  = hart_idx(addr_a, SSIP_BASE, 2);
        sel_msip  = msip_idx < NR_HARTS;
        sel_cmp   = cmp_idx < NR_HARTS;
        sel_mtime = addr_a == MTIME_BASE;
        sel_ssip  = ssip_idx < NR_HARTS;
        wr        = req_i & we_i;
    end

    // Software-interrupt beats pack hart 2k at bit 0 and hart 2k+1 at bit 32.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (sel_msip) begin
            for (int h = 0; h < NR_HARTS; h++) begin
                if (h == msip_idx)     rd_data[0]  = msip_q[h];
                if (h == msip_idx + 1) rd_data[32] = msip_q[h];
            end
        end else if (sel_cmp) begin
            for (int h = 0; h < NR_HARTS; h++) begin
                if (h == cmp_idx) rd_data = mtimecmp_q[h];
            end
        end else if (sel_mtime) begin
            rd_data = mtime_q;
        end else if (sel_ssip) begin
            for (int h = 0; h < NR_HARTS; h++) begin
                if (h == ssip_idx)     rd_data[0]  = ssip_q[h];
                if (h == ssip_idx + 1) rd_data[32] = ssip_q[h];
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= (req_i && !we_i) ? rd_data : '0;
            err_q    <= req_i & rd_err;
        end
    end

    // A software write to mtime wins over the tick of the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q <= '0;
        end else if (wr && sel_mtime && (|be_i)) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) mtime_q[8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end else if (tick && !stop_i) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int h = 0; h < NR_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
            msip_q <= '0;
            ssip_q <= '0;
            irq_q  <= '0;
        end else begin
            for (int h = 0; h < NR_HARTS; h++) begin
                irq_q[h] <= mtime_q >= mtimecmp_q[h];
                if (wr && sel_cmp && h == cmp_idx) begin
                    for (int b = 0; b < 8; b++) begin
                        if (be_i[b]) mtimecmp_q[h][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
                if (wr && sel_msip) begin
                    if (h == msip_idx && be_i[0])     msip_q[h] <= wdata_i[0];
                    if (h == msip_idx + 1 && be_i[4]) msip_q[h] <= wdata_i[32];
                end
                if (wr && sel_ssip) begin
                    if (h == ssip_idx && be_i[0])     ssip_q[h] <= wdata_i[0];
                    if (h == ssip_idx + 1 && be_i[4]) ssip_q[h] <= wdata_i[32];
                end
            end
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign timer_irq_o = irq_q;
    assign ipi_o       = msip_q;
    assign sip_o       = ssip_q;

endmodule
